// File: rtl/bmu.sv
// Single-cycle registered bit-manipulation ALU with base logic/shift/add ops,
// a Zba/Zbb/Zbp/Zbs subset, and CSR read-data pass-through on one result register.
module bmu (
   input  logic               clk,
   input  logic               rst_l,
   input  logic               scan_mode,
   input  logic               valid_in,
   input  logic [22:0]        ap,
   input  logic               csr_ren_in,
   input  logic [31:0]        csr_rddata_in,
   input  logic signed [31:0] a_in,
   input  logic signed [31:0] b_in,
   output logic [31:0]        result_ff,
   output logic               error
);

   // Leading-zero count; an all-zero input yields 32.
   function automatic logic [5:0] clz32(input logic [31:0] v);
      logic [5:0] n;
      logic       found;
      n     = 6'd0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) found = 1'b1;
         else if (!found) n = n + 6'd1;
      end
      return n;
   endfunction

   function automatic logic [5:0] cpop32(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd0;
      for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
      return n;
   endfunction

   function automatic logic [31:0] orc_b(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{|v[i*8 +: 8]}};
      return r;
   endfunction

   logic csr_write, csr_imm, zbb, zbp, zba, zbs;
   logic op_land, op_lxor, op_sll, op_sra, op_rol, op_bext, op_sh3add;
   logic op_add, op_slt, unsign, sub;
   logic op_clz, op_cpop, op_siext_h, op_min, op_packu, op_gorc;

   assign {csr_write, csr_imm, zbb, zbp, zba, zbs,
           op_land, op_lxor, op_sll, op_sra, op_rol, op_bext, op_sh3add,
           op_add, op_slt, unsign, sub,
           op_clz, op_cpop, op_siext_h, op_min, op_packu, op_gorc} = ap;

   // scan_mode carries no functional meaning for this unit.
   logic unused_scan;
   assign unused_scan = scan_mode;

   logic        vld_p0;
   logic [15:0] ops_p0;
   logic        ext_miss_p0;
   logic        illegal_p0;
   logic [4:0]  sh_p0;
   logic        lt_p0;
   logic [63:0] rol_w_p0;
   logic [31:0] res_p0;

   assign vld_p0 = valid_in;
   assign sh_p0  = b_in[4:0];
   assign ops_p0 = {csr_write, op_land, op_lxor, op_sll, op_sra, op_rol, op_bext,
                    op_sh3add, op_add, op_slt, op_clz, op_cpop, op_siext_h,
                    op_min, op_packu, op_gorc};

   assign ext_miss_p0 = (op_rol     & ~zbb) | (op_bext  & ~zbs) |
                        (op_sh3add  & ~zba) | (op_clz   & ~zbb) |
                        (op_cpop    & ~zbb) | (op_siext_h & ~zbb) |
                        (op_min     & ~zbb) | (op_packu & ~zbp) |
                        (op_gorc    & ~(zbp | zbb));
   assign illegal_p0  = ~$onehot(ops_p0) | ext_miss_p0;

   assign lt_p0    = unsign ? ($unsigned(a_in) < $unsigned(b_in)) : (a_in < b_in);
   assign rol_w_p0 = {a_in, a_in} << sh_p0;

   always_comb begin
      res_p0 = 32'd0;
      if (csr_write)       res_p0 = csr_imm ? b_in : a_in;
      else if (op_land)    res_p0 = zbb ? (a_in & ~b_in) : (a_in & b_in);
      else if (op_lxor)    res_p0 = zbb ? ~(a_in ^ b_in) : (a_in ^ b_in);
      else if (op_sll)     res_p0 = a_in << sh_p0;
      else if (op_sra)     res_p0 = a_in >>> sh_p0;
      else if (op_rol)     res_p0 = rol_w_p0[63:32];
      else if (op_bext)    res_p0 = {31'd0, a_in[sh_p0]};
      else if (op_sh3add)  res_p0 = (a_in <<< 3) + b_in;
      else if (op_add)     res_p0 = sub ? (a_in - b_in) : (a_in + b_in);
      else if (op_slt)     res_p0 = {31'd0, lt_p0};
      else if (op_clz)     res_p0 = {26'd0, clz32(a_in)};
      else if (op_cpop)    res_p0 = {26'd0, cpop32(a_in)};
      else if (op_siext_h) res_p0 = {{16{a_in[15]}}, a_in[15:0]};
      else if (op_min)     res_p0 = lt_p0 ? a_in : b_in;
      else if (op_packu)   res_p0 = {b_in[31:16], a_in[31:16]};
      else if (op_gorc)    res_p0 = orc_b(a_in);
   end

   // p0 -> output register: CSR read beats any ALU request; idle clears outputs.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         result_ff <= 32'd0;
         error     <= 1'b0;
      end else if (csr_ren_in) begin
         result_ff <= csr_rddata_in;
         error     <= 1'b0;
      end else if (vld_p0 && illegal_p0) begin
         result_ff <= 32'd0;
         error     <= 1'b1;
      end else if (vld_p0) begin
         result_ff <= res_p0;
         error     <= 1'b0;
      end else begin
         result_ff <= 32'd0;
         error     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bmu.sv
// Directed testbench for bmu: one linear sequence of steps, each checked one cycle later.
module tb_bmu;

   localparam logic [22:0] CSRW  = 23'h1 << 22;
   localparam logic [22:0] CIMM  = 23'h1 << 21;
   localparam logic [22:0] ZBB   = 23'h1 << 20;
   localparam logic [22:0] ZBP   = 23'h1 << 19;
   localparam logic [22:0] ZBA   = 23'h1 << 18;
   localparam logic [22:0] ZBS   = 23'h1 << 17;
   localparam logic [22:0] LAND  = 23'h1 << 16;
   localparam logic [22:0] LXOR  = 23'h1 << 15;
   localparam logic [22:0] SLL   = 23'h1 << 14;
   localparam logic [22:0] SRA   = 23'h1 << 13;
   localparam logic [22:0] ROL   = 23'h1 << 12;
   localparam logic [22:0] BEXT  = 23'h1 << 11;
   localparam logic [22:0] SH3A  = 23'h1 << 10;
   localparam logic [22:0] ADD   = 23'h1 << 9;
   localparam logic [22:0] SLT   = 23'h1 << 8;
   localparam logic [22:0] UNS   = 23'h1 << 7;
   localparam logic [22:0] SUB   = 23'h1 << 6;
   localparam logic [22:0] CLZ   = 23'h1 << 5;
   localparam logic [22:0] CPOP  = 23'h1 << 4;
   localparam logic [22:0] SEXTH = 23'h1 << 3;
   localparam logic [22:0] MIN   = 23'h1 << 2;
   localparam logic [22:0] PACKU = 23'h1 << 1;
   localparam logic [22:0] GORC  = 23'h1 << 0;

   logic               clk = 1'b0;
   logic               rst_l;
   logic               scan_mode;
   logic               valid_in;
   logic [22:0]        ap;
   logic               csr_ren_in;
   logic [31:0]        csr_rddata_in;
   logic signed [31:0] a_in;
   logic signed [31:0] b_in;
   logic [31:0]        result_ff;
   logic               error;

   int passes = 0;
   int checks = 0;

   bmu dut (
      .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .valid_in(valid_in),
      .ap(ap), .csr_ren_in(csr_ren_in), .csr_rddata_in(csr_rddata_in),
      .a_in(a_in), .b_in(b_in), .result_ff(result_ff), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request for one cycle, then check both outputs after the edge.
   task automatic step(input string tag, input logic rst, input logic vld,
                       input logic [22:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic ren, input logic [31:0] rdata,
                       input logic [31:0] exp_res, input logic exp_err);
      rst_l         = rst;
      valid_in      = vld;
      ap            = ctl;
      a_in          = a;
      b_in          = b;
      csr_ren_in    = ren;
      csr_rddata_in = rdata;
      @(posedge clk);
      #1;
      check({tag, ".res"}, result_ff, exp_res);
      check({tag, ".err"}, {31'd0, error}, {31'd0, exp_err});
   endtask

   initial begin
      scan_mode = 1'b0;
      rst_l = 1'b1; valid_in = 1'b0; ap = '0; a_in = '0; b_in = '0;
      csr_ren_in = 1'b0; csr_rddata_in = '0;
      @(posedge clk);
      #1;
      step("reset_add",  1'b1, 1'b1, ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      step("add",        1'b0, 1'b1, ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 1'b0);
      step("add_uns",    1'b0, 1'b1, ADD | UNS, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'd1, 1'b0);
      step("sub",        1'b0, 1'b1, ADD | SUB, 32'd3, 32'd5, 1'b0, 32'd0, 32'hFFFFFFFE, 1'b0);
      step("slt_s",      1'b0, 1'b1, SLT, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'd1, 1'b0);
      step("slt_u",      1'b0, 1'b1, SLT | UNS, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0);
      step("min",        1'b0, 1'b1, MIN | ZBB, 32'hFFFFFFFC, 32'd2, 1'b0, 32'd0, 32'hFFFFFFFC, 1'b0);
      step("min_u",      1'b0, 1'b1, MIN | ZBB | UNS, 32'hFFFFFFFC, 32'd2, 1'b0, 32'd0, 32'd2, 1'b0);
      step("clz0",       1'b0, 1'b1, CLZ | ZBB, 32'd0, 32'd0, 1'b0, 32'd0, 32'd32, 1'b0);
      step("clz15",      1'b0, 1'b1, CLZ | ZBB, 32'h00010000, 32'd0, 1'b0, 32'd0, 32'd15, 1'b0);
      step("cpop",       1'b0, 1'b1, CPOP | ZBB, 32'hF0F0F0F0, 32'd0, 1'b0, 32'd0, 32'd16, 1'b0);
      step("rol",        1'b0, 1'b1, ROL | ZBB, 32'h80000001, 32'd1, 1'b0, 32'd0, 32'h00000003, 1'b0);
      step("gorc",       1'b0, 1'b1, GORC | ZBP, 32'h00120000, 32'd0, 1'b0, 32'd0, 32'h00FF0000, 1'b0);
      step("packu",      1'b0, 1'b1, PACKU | ZBP, 32'h1234ABCD, 32'h5678EF01, 1'b0, 32'd0, 32'h56781234, 1'b0);
      step("sra",        1'b0, 1'b1, SRA, 32'h80000000, 32'd31, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0);
      step("sll",        1'b0, 1'b1, SLL, 32'd1, 32'd4, 1'b0, 32'd0, 32'd16, 1'b0);
      step("bext",       1'b0, 1'b1, BEXT | ZBS, 32'h8, 32'd3, 1'b0, 32'd0, 32'd1, 1'b0);
      step("sh3add",     1'b0, 1'b1, SH3A | ZBA, 32'd2, 32'd1, 1'b0, 32'd0, 32'd17, 1'b0);
      step("sexth",      1'b0, 1'b1, SEXTH | ZBB, 32'h00008001, 32'd0, 1'b0, 32'd0, 32'hFFFF8001, 1'b0);
      step("andn",       1'b0, 1'b1, LAND | ZBB, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'd0, 32'h000000F0, 1'b0);
      step("and",        1'b0, 1'b1, LAND, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'd0, 32'h0000F000, 1'b0);
      step("xnor",       1'b0, 1'b1, LXOR | ZBB, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 32'd0, 32'hF00FF00F, 1'b0);
      step("err_two",    1'b0, 1'b1, ADD | SLL, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b1);
      step("err_noext",  1'b0, 1'b1, CLZ, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      step("err_none",   1'b0, 1'b1, 23'd0, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b1);
      step("idle",       1'b0, 1'b0, ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      step("csr_read",   1'b0, 1'b1, ADD | SLL, 32'd5, 32'd7, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      step("csrw_imm",   1'b0, 1'b1, CSRW | CIMM, 32'h12345678, 32'h1F, 1'b0, 32'd0, 32'h1F, 1'b0);
      step("csrw_reg",   1'b0, 1'b1, CSRW, 32'h12345678, 32'h1F, 1'b0, 32'd0, 32'h12345678, 1'b0);
      step("rst_mid",    1'b1, 1'b1, ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
